reg7_serial_tx: RTL and testbench
=================================

Name: reg7_serial_tx

Overview:
- Transmit side of the 7-bit register datapath.
- Accepts a parallel word from a register stage over a valid/ready handshake and serialises it onto one line.
- Line format: start bit, data LSB first, optional even parity, stop bit.
- The far end is a matching serial receiver that reloads a 7-bit register.

Parameters:
- WIDTH, 7: data bits per frame.
- BAUD_DIV, 4: clock cycles per line bit; legal range 1..65535.
- PARITY_EN, 1: 1 = insert even-parity bit after data; 0 = omit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  producer offers load_data this cycle.
- load_data  input  WIDTH  word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- tx_line  output  1  serial line, registered, idles high.
- busy  output  1  frame in progress (any state except IDLE).
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset is one clock; reset wins over every other input in the same cycle.
  - After the reset edge: state=IDLE, tx_line=1, busy=0, done=0, shift reg=0, bit/baud counters=0.
  - load_ready=0 while reset is high; load_ready=1 from the first cycle after reset deasserts.
- load_ready = (state==IDLE) && !reset, combinational from state.
- Accept occurs when load_valid && load_ready at a rising edge.
  - load_data is captured into the shift register.
  - Parity is computed as XOR of load_data (even parity).
  - state moves to START; tx_line=0 from that edge.
- Data is held only after acceptance. load_data changes after the accept edge have no effect on the frame in progress.
- States and transitions:
  - IDLE: tx_line=1. Go to START on accept.
  - START: tx_line=0 for BAUD_DIV cycles, then DATA.
  - DATA: tx_line=shift[0]. Shift right every BAUD_DIV cycles. After WIDTH bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_line=parity for BAUD_DIV cycles, then STOP.
  - STOP: tx_line=1 for BAUD_DIV cycles, then IDLE.
- Baud counter counts 0..BAUD_DIV-1, reloads to 0 on every bit boundary, and is 16 bits wide.
- BAUD_DIV=1: each line bit lasts exactly one cycle.
- Bit counter counts 0..WIDTH-1 in DATA and is sized $clog2(WIDTH+1).
- Frame length is (WIDTH+2+PARITY_EN)*BAUD_DIV cycles, measured from the accept edge to the edge returning to IDLE.
  - Defaults: 10*4 = 40 cycles.
- done is asserted in the first IDLE cycle after STOP, for exactly one cycle, at the same time load_ready=1.
- Back-to-back frames:
  - An accept in the done cycle starts the next frame immediately.
  - The line shows no extra idle bit beyond the stop bit.
- load_valid while busy is ignored: no capture, no error. The producer must hold load_valid until load_ready.
- Reset mid-frame aborts the frame. On the next edge tx_line=1 and state=IDLE; done is not pulsed for an aborted frame.
- busy equals (state!=IDLE), registered, with no combinational path from inputs.

Test Plan:
- Reset check: hold reset=1 for 2 cycles with load_valid=1 and load_data=7'b0000111.
  -> tx_line=1, busy=0, done=0, load_ready=0 throughout reset.
  -> Nothing is accepted; load_ready=1 in the first cycle after release.
- Single frame, BAUD_DIV=2, PARITY_EN=1: load 7'b0000111.
  -> tx_line sequence per 2-cycle bit: 0 | 1,1,1,0,0,0,0 | 1 (parity) | 1 (stop).
  -> busy=1 for 20 cycles; done pulses once at cycle 21.
- Parity variants: load 7'b0000000 -> parity bit 0; load 7'b1111111 -> parity bit 1.
  - PARITY_EN=0 with 7'b1010101 -> frame is 9 bits, 0|1,0,1,0,1,0,1|1, with 18 cycles busy.
- Back-to-back: BAUD_DIV=1, load_valid held high with 7'h55 then 7'h2A.
  -> Second start bit appears directly after the first stop bit.
  -> done pulses once per frame, with no idle gap between frames.
- Busy rejection: mid-frame, change load_data to 7'h7F with load_valid=1.
  -> Current frame bits are unchanged.
  -> 7'h7F is transmitted only after done, as the next frame.
- Mid-frame reset: assert reset during DATA bit 3.
  -> Next edge gives tx_line=1, busy=0, with no done pulse.
  -> A fresh load of 7'b0000111 afterwards transmits a complete, correct frame.

Source files
------------

// File: rtl/reg7_serial_tx.sv
// Serialiser for the 7-bit register datapath: start bit, LSB-first data,
// optional even parity, stop bit, with a valid/ready load handshake.
module reg7_serial_tx #(
  parameter int WIDTH     = 7,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             tx_line,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int              BW        = $clog2(WIDTH + 1);
  localparam logic [15:0]     BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(WIDTH - 1);

  logic [2:0]       state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             parity_reg;
  logic [15:0]      baud_cnt_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             baud_end;
  logic [WIDTH-1:0] shift_next;

  assign baud_end   = (baud_cnt_reg == BAUD_LAST);
  assign shift_next = shift_reg >> 1;

  assign load_ready = (state_reg == S_IDLE) && !reset;
  assign tx_line    = tx_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

  // tx_reg is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and stays glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg != S_IDLE) begin
        baud_cnt_reg <= baud_end ? 16'd0 : baud_cnt_reg + 16'd1;
      end
      case (state_reg)
        S_IDLE: begin
          if (load_valid) begin
            shift_reg    <= load_data;
            parity_reg   <= ^load_data;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= S_START;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        S_START: begin
          if (baud_end) begin
            state_reg <= S_DATA;
            tx_reg    <= shift_reg[0];
          end
        end
        S_DATA: begin
          if (baud_end) begin
            shift_reg <= shift_next;
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_reg <= '0;
              if (PARITY_EN != 0) begin
                state_reg <= S_PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= S_STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
              tx_reg      <= shift_next[0];
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            state_reg <= S_STOP;
            tx_reg    <= 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            state_reg <= S_IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg7_serial_tx.sv
// Drives three transmitter configurations from shared stimulus and compares
// every cycle against a frame-waveform reference model.
module tb_reg7_serial_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b1;
  logic [6:0] load_data = 7'b0000111;

  logic tx [3];
  logic bsy [3];
  logic dn [3];
  logic rdy [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // u0: 2 cycles/bit with parity, u1: 2 cycles/bit no parity, u2: 1 cycle/bit with parity
  reg7_serial_tx #(.WIDTH(7), .BAUD_DIV(2), .PARITY_EN(1)) u0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy[0]), .tx_line(tx[0]), .busy(bsy[0]), .done(dn[0]));
  reg7_serial_tx #(.WIDTH(7), .BAUD_DIV(2), .PARITY_EN(0)) u1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy[1]), .tx_line(tx[1]), .busy(bsy[1]), .done(dn[1]));
  reg7_serial_tx #(.WIDTH(7), .BAUD_DIV(1), .PARITY_EN(1)) u2 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy[2]), .tx_line(tx[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bd(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic int pe(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  // Line level of bit number idx of a frame carrying w.
  function automatic logic frame_bit(input logic [6:0] w, input int idx, input int p);
    if (idx == 0) return 1'b0;
    if (idx <= 7) return w[idx-1];
    if (idx == 8 && p != 0) return ^w;
    return 1'b1;
  endfunction

  bit         act [3];
  int         pos [3];
  logic [6:0] word [3];
  bit         dexp [3];
  bit         started = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        act[k] = 0; pos[k] = 0; dexp[k] = 0;
      end else begin
        dexp[k] = 0;
        if (act[k]) begin
          pos[k]++;
          if (pos[k] == (7 + 2 + pe(k)) * bd(k)) begin
            act[k] = 0;
            dexp[k] = 1;
          end
        end else if (load_valid) begin
          act[k] = 1; pos[k] = 0; word[k] = load_data;
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic e_tx;
        e_tx = act[k] ? frame_bit(word[k], pos[k] / bd(k), pe(k)) : 1'b1;
        check($sformatf("u%0d.tx_line", k), {31'd0, tx[k]}, {31'd0, e_tx});
        check($sformatf("u%0d.busy", k), {31'd0, bsy[k]}, {31'd0, act[k]});
        check($sformatf("u%0d.done", k), {31'd0, dn[k]}, {31'd0, dexp[k]});
        check($sformatf("u%0d.load_ready", k), {31'd0, rdy[k]},
              {31'd0, (!act[k] && !reset)});
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [6:0] d, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      reset = r; load_valid = v; load_data = d;
    end
  endtask

  initial begin
    step(1'b1, 1'b1, 7'b0000111, 1);            // reset held over two edges
    step(1'b0, 1'b0, 7'b0000111, 2);
    step(1'b0, 1'b1, 7'b0000111, 1);            // single frame
    step(1'b0, 1'b0, 7'b0000111, 25);
    step(1'b0, 1'b1, 7'b0000000, 1);            // parity 0
    step(1'b0, 1'b0, 7'b0000000, 25);
    step(1'b0, 1'b1, 7'b1111111, 1);            // parity 1
    step(1'b0, 1'b0, 7'b1111111, 25);
    step(1'b0, 1'b1, 7'b1010101, 1);
    step(1'b0, 1'b0, 7'b1010101, 25);
    step(1'b0, 1'b1, 7'h55, 12);                // back-to-back with valid held
    step(1'b0, 1'b1, 7'h2A, 30);
    step(1'b0, 1'b0, 7'h2A, 25);
    step(1'b0, 1'b1, 7'h33, 1);                 // busy rejection
    step(1'b0, 1'b0, 7'h33, 5);
    step(1'b0, 1'b1, 7'h7F, 30);
    step(1'b0, 1'b0, 7'h7F, 25);
    step(1'b0, 1'b1, 7'b0000111, 1);            // mid-frame reset during data
    step(1'b0, 1'b0, 7'b0000111, 9);
    step(1'b1, 1'b0, 7'b0000111, 1);
    step(1'b0, 1'b1, 7'b0000111, 1);
    step(1'b0, 1'b0, 7'b0000111, 25);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           7'($urandom), 1);
    end
    step(1'b0, 1'b0, 7'h00, 30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
